// File: rtl/slider_movegen.sv
// ============================================================================
// Module   : slider_movegen
// Purpose  : Sliding/stepping move generator. It walks the enabled ray
//            directions from a source square on an SDRAM board and records
//            each legal target. It then writes one complete successor board
//            per target into a packed destination area.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slider_movegen #(
  parameter logic [7:0] DIR_MASK   = 8'hFF,
  parameter int         MAX_STEPS  = 7,
  parameter int         MAX_BOARDS = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam int            CW        = $clog2(MAX_BOARDS + 1);
  localparam int            LW        = (MAX_BOARDS > 1) ? $clog2(MAX_BOARDS) : 1;
  localparam logic [3:0]    MAX_K     = 4'(MAX_STEPS);
  localparam logic [CW-1:0] LIST_FULL = CW'(MAX_BOARDS);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SRC, S_WT_SRC, S_NEXT_DIR, S_STEP, S_RD_DST, S_WT_DST,
    S_EVAL, S_CP_INIT, S_CP_RD, S_CP_WT, S_CP_WR, S_DONE
  } state_t;

  state_t        state_q;
  logic [31:0]   src_base_q, dst_base_q;
  logic [2:0]    src_x_q, src_y_q;
  logic [7:0]    src_piece_q, tgt_piece_q;
  logic [2:0]    dir_q;
  logic [3:0]    dir_scan_q;          // next direction index still to be considered (0..8)
  logic [3:0]    k_q;
  logic [3:0]    cur_x_q, cur_y_q;    // two's complement, so -1 and 8 both show up as bit 3 set
  logic [5:0]    list_q [MAX_BOARDS];
  logic [CW-1:0] count_q, n_q;
  logic [5:0]    i_q;
  logic [31:0]   rdata_q, addr_q, wdata_q;
  logic          read_q, write_q;

  logic          busy;
  logic [1:0]    status;
  logic [5:0]    src_sq, cur_sq;
  logic          scan_hit;
  logic [2:0]    scan_dir;
  logic [7:0]    rd_piece;
  logic [23:0]   unused_rd_bits;

  assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
  assign status            = (state_q == S_IDLE) ? 2'd0 : (state_q == S_DONE) ? 2'd2 : 2'd1;
  assign src_sq            = {src_y_q, src_x_q};
  assign cur_sq            = {cur_y_q[2:0], cur_x_q[2:0]};
  assign rd_piece          = master_readdata[7:0];
  assign unused_rd_bits    = master_readdata[31:8];

  assign slave_waitrequest = slave_write & busy;
  assign slave_readdata    = rdata_q;
  assign master_address    = addr_q;
  assign master_read       = read_q;
  assign master_write      = write_q;
  assign master_writedata  = wdata_q;

  function automatic logic [3:0] delta_x(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: delta_x = 4'd1;
      3'd5, 3'd6, 3'd7: delta_x = 4'hF;
      default:          delta_x = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] delta_y(input logic [2:0] d);
    case (d)
      3'd7, 3'd0, 3'd1: delta_y = 4'd1;
      3'd3, 3'd4, 3'd5: delta_y = 4'hF;
      default:          delta_y = 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] sq_addr(input logic [31:0] base, input logic [5:0] sq);
    return base + {24'd0, sq, 2'b00};
  endfunction

  function automatic logic [31:0] sext(input logic [7:0] p);
    return {{24{p[7]}}, p};
  endfunction

  // Lowest enabled direction at or above the scan pointer (descending loop so the lowest wins).
  always_comb begin
    scan_hit = 1'b0;
    scan_dir = 3'd0;
    for (int d = 7; d >= 0; d--) begin
      if (DIR_MASK[d] && (4'(d) >= dir_scan_q)) begin
        scan_hit = 1'b1;
        scan_dir = 3'(d);
      end
    end
  end

  // Register file, ray walk, board copy and Avalon master handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      src_piece_q <= '0;
      tgt_piece_q <= '0;
      dir_q       <= '0;
      dir_scan_q  <= '0;
      k_q         <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      count_q     <= '0;
      n_q         <= '0;
      i_q         <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      for (int e = 0; e < MAX_BOARDS; e++) list_q[e] <= '0;
    end else begin
      if (slave_read) begin
        case (slave_address)
          4'd0:    rdata_q <= {30'd0, status};
          4'd5:    rdata_q <= 32'(count_q);
          4'd6:    rdata_q <= {24'd0, DIR_MASK};
          default: rdata_q <= '0;
        endcase
      end

      // Configuration writes land only when not busy; a busy write is held off by waitrequest.
      if (slave_write && !busy) begin
        case (slave_address)
          4'd1:    src_base_q <= slave_writedata;
          4'd2:    dst_base_q <= slave_writedata;
          4'd3:    src_x_q    <= slave_writedata[2:0];
          4'd4:    src_y_q    <= slave_writedata[2:0];
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (slave_write && (slave_address == 4'd0)) begin
            count_q <= '0;
            read_q  <= 1'b1;
            addr_q  <= sq_addr(src_base_q, src_sq);
            state_q <= S_RD_SRC;
          end
        end
        S_RD_SRC: begin
          if (!master_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= S_WT_SRC;
          end
        end
        S_WT_SRC: begin
          if (master_readdatavalid) begin
            src_piece_q <= rd_piece;
            dir_scan_q  <= '0;
            state_q     <= (rd_piece == 8'd0) ? S_DONE : S_NEXT_DIR;
          end
        end
        S_NEXT_DIR: begin
          if (scan_hit) begin
            dir_q      <= scan_dir;
            dir_scan_q <= {1'b0, scan_dir} + 4'd1;
            k_q        <= 4'd1;
            cur_x_q    <= {1'b0, src_x_q} + delta_x(scan_dir);
            cur_y_q    <= {1'b0, src_y_q} + delta_y(scan_dir);
            state_q    <= S_STEP;
          end else begin
            state_q    <= S_CP_INIT;
          end
        end
        S_STEP: begin
          if (cur_x_q[3] || cur_y_q[3]) begin
            state_q <= S_NEXT_DIR;
          end else begin
            read_q  <= 1'b1;
            addr_q  <= sq_addr(src_base_q, cur_sq);
            state_q <= S_RD_DST;
          end
        end
        S_RD_DST: begin
          if (!master_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= S_WT_DST;
          end
        end
        S_WT_DST: begin
          if (master_readdatavalid) begin
            tgt_piece_q <= rd_piece;
            state_q     <= S_EVAL;
          end
        end
        S_EVAL: begin
          if ((tgt_piece_q != 8'd0) && (tgt_piece_q[7] == src_piece_q[7])) begin
            state_q <= S_NEXT_DIR;
          end else if (count_q == LIST_FULL) begin
            state_q <= S_CP_INIT;
          end else begin
            list_q[count_q[LW-1:0]] <= cur_sq;
            count_q                 <= count_q + CW'(1);
            if ((tgt_piece_q != 8'd0) || (k_q >= MAX_K)) begin
              state_q <= S_NEXT_DIR;
            end else begin
              k_q     <= k_q + 4'd1;
              cur_x_q <= cur_x_q + delta_x(dir_q);
              cur_y_q <= cur_y_q + delta_y(dir_q);
              state_q <= S_STEP;
            end
          end
        end
        S_CP_INIT: begin
          n_q <= '0;
          i_q <= '0;
          if (count_q == '0) begin
            state_q <= S_DONE;
          end else begin
            read_q  <= 1'b1;
            addr_q  <= sq_addr(src_base_q, 6'd0);
            state_q <= S_CP_RD;
          end
        end
        S_CP_RD: begin
          if (!master_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= S_CP_WT;
          end
        end
        S_CP_WT: begin
          if (master_readdatavalid) begin
            write_q <= 1'b1;
            addr_q  <= dst_base_q + (32'(n_q) << 8) + {24'd0, i_q, 2'b00};
            if (i_q == list_q[n_q[LW-1:0]]) wdata_q <= sext(src_piece_q);
            else if (i_q == src_sq)         wdata_q <= '0;
            else                            wdata_q <= sext(rd_piece);
            state_q <= S_CP_WR;
          end
        end
        S_CP_WR: begin
          if (!master_waitrequest) begin
            write_q <= 1'b0;
            if (i_q == 6'd63) begin
              if (n_q == count_q - CW'(1)) begin
                state_q <= S_DONE;
              end else begin
                n_q     <= n_q + CW'(1);
                i_q     <= '0;
                read_q  <= 1'b1;
                addr_q  <= sq_addr(src_base_q, 6'd0);
                state_q <= S_CP_RD;
              end
            end else begin
              i_q     <= i_q + 6'd1;
              read_q  <= 1'b1;
              addr_q  <= sq_addr(src_base_q, i_q + 6'd1);
              state_q <= S_CP_RD;
            end
          end
        end
        S_DONE: begin
          // Reading status acknowledges completion.
          if (slave_read && (slave_address == 4'd0)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slider_movegen.sv
// ============================================================================
// Module   : tb_slider_movegen
// Purpose  : Self-checking bench for slider_movegen. Three instances (queen,
//            rook, shallow-list king) share one CPU driver and one SDRAM model;
//            results are compared against a ray-walking reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slider_movegen;

  localparam int DW = 27 * 64;   // destination area in words

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;

  logic [3:0]  s_addr = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_wdata = '0;
  logic        s_rd_i [3], s_wr_i [3], s_wait [3];
  logic [31:0] s_rdata [3];
  logic [31:0] m_addr [3], m_wdata [3];
  logic        m_read [3], m_write [3], m_valid_i [3];
  logic        m_wait = 1'b0, m_valid = 1'b0;
  logic [31:0] m_rdata = '0;

  for (genvar j = 0; j < 3; j++) begin : g_gate
    assign s_rd_i[j]    = s_read  && (sel == j);
    assign s_wr_i[j]    = s_write && (sel == j);
    assign m_valid_i[j] = m_valid && (sel == j);
  end

  logic        cur_read, cur_write, cur_swait;
  logic [31:0] cur_addr, cur_wdata, cur_srdata;
  assign cur_read   = m_read[sel];
  assign cur_write  = m_write[sel];
  assign cur_addr   = m_addr[sel];
  assign cur_wdata  = m_wdata[sel];
  assign cur_swait  = s_wait[sel];
  assign cur_srdata = s_rdata[sel];

  slider_movegen #(.DIR_MASK(8'hFF), .MAX_STEPS(7), .MAX_BOARDS(27)) u_queen (
    .clk(clk), .rst_n(rst_n), .slave_waitrequest(s_wait[0]), .slave_address(s_addr),
    .slave_read(s_rd_i[0]), .slave_readdata(s_rdata[0]), .slave_write(s_wr_i[0]),
    .slave_writedata(s_wdata), .master_waitrequest(m_wait), .master_address(m_addr[0]),
    .master_read(m_read[0]), .master_readdata(m_rdata), .master_readdatavalid(m_valid_i[0]),
    .master_write(m_write[0]), .master_writedata(m_wdata[0]));

  slider_movegen #(.DIR_MASK(8'h55), .MAX_STEPS(7), .MAX_BOARDS(27)) u_rook (
    .clk(clk), .rst_n(rst_n), .slave_waitrequest(s_wait[1]), .slave_address(s_addr),
    .slave_read(s_rd_i[1]), .slave_readdata(s_rdata[1]), .slave_write(s_wr_i[1]),
    .slave_writedata(s_wdata), .master_waitrequest(m_wait), .master_address(m_addr[1]),
    .master_read(m_read[1]), .master_readdata(m_rdata), .master_readdatavalid(m_valid_i[1]),
    .master_write(m_write[1]), .master_writedata(m_wdata[1]));

  slider_movegen #(.DIR_MASK(8'hFF), .MAX_STEPS(1), .MAX_BOARDS(4)) u_king (
    .clk(clk), .rst_n(rst_n), .slave_waitrequest(s_wait[2]), .slave_address(s_addr),
    .slave_read(s_rd_i[2]), .slave_readdata(s_rdata[2]), .slave_write(s_wr_i[2]),
    .slave_writedata(s_wdata), .master_waitrequest(m_wait), .master_address(m_addr[2]),
    .master_read(m_read[2]), .master_readdata(m_rdata), .master_readdatavalid(m_valid_i[2]),
    .master_write(m_write[2]), .master_writedata(m_wdata[2]));

  // ---------------- SDRAM model: source board at 0x1000, destination at 0x2000
  logic [31:0] smem [64];
  logic [31:0] dmem [DW];
  int          dtag [DW];
  int          run_id = 0;
  bit          rand_wait = 1'b0;
  int          n_rd = 0, n_wr = 0, bad_acc = 0;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [31:0] pdata = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      m_valid <= 1'b0;
      m_wait  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (pend) begin
        if (lat <= 1) begin
          m_valid <= 1'b1;
          m_rdata <= pdata;
          pend    <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
      if (cur_read && !m_wait) begin
        if (pend) bad_acc <= bad_acc + 1;
        n_rd <= n_rd + 1;
        if (cur_addr >= 32'h1000 && cur_addr < 32'h1100 && cur_addr[1:0] == 2'b00)
          pdata <= smem[(cur_addr - 32'h1000) >> 2];
        else begin
          pdata   <= 32'hBAD0BAD0;
          bad_acc <= bad_acc + 1;
        end
        pend <= 1'b1;
        lat  <= rand_wait ? int'($urandom_range(1, 5)) : 1;
      end
      if (cur_write && !m_wait) begin
        n_wr <= n_wr + 1;
        if (cur_addr >= 32'h2000 && cur_addr < 32'h2000 + 4 * DW && cur_addr[1:0] == 2'b00) begin
          dmem[(cur_addr - 32'h2000) >> 2] <= cur_wdata;
          dtag[(cur_addr - 32'h2000) >> 2] <= run_id;
        end else begin
          bad_acc <= bad_acc + 1;
        end
      end
      m_wait <= rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- checking
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: walk rays with plain integer geometry
  int          bd [64];
  int          exp_t [$];
  int          exp_reads;
  logic [7:0]  MASKS [3] = '{8'hFF, 8'h55, 8'hFF};
  int          STEPS [3] = '{7, 7, 1};
  int          MAXB  [3] = '{27, 27, 4};

  function automatic void ref_model(input int sx, input int sy, input logic [7:0] mask,
                                    input int ms, input int mb);
    int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int p, x, y, t;
    bit full;
    exp_t.delete();
    exp_reads = 1;
    p = bd[8 * sy + sx];
    full = 1'b0;
    if (p == 0) return;
    for (int d = 0; d < 8; d++) begin
      if (mask[d] && !full) begin
        for (int k = 1; k <= ms; k++) begin
          x = sx + k * dxs[d];
          y = sy + k * dys[d];
          if (x < 0 || x > 7 || y < 0 || y > 7) break;
          exp_reads++;
          t = bd[8 * y + x];
          if (t != 0 && ((t > 0) == (p > 0))) break;
          if (exp_t.size() == mb) begin full = 1'b1; break; end
          exp_t.push_back(8 * y + x);
          if (t != 0) break;
        end
      end
    end
    exp_reads += 64 * exp_t.size();
  endfunction

  // ---------------- CPU side
  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d, output int stall);
    @(negedge clk);
    s_addr = a; s_wdata = d; s_write = 1'b1; stall = 0;
    #1;
    while (cur_swait && stall < 40000) begin
      @(negedge clk); #1; stall++;
    end
    if (stall >= 40000) check("write_timeout", 32'(stall), 32'd0);
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int st;
    cpu_write(a, d, st);
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    s_addr = a; s_read = 1'b1;
    @(posedge clk); #1;
    d = cur_srdata;
    s_read = 1'b0;
  endtask

  int r0, w0, b0, last_count, sx_g, sy_g;

  task automatic start_run(input int s, input int sx, input int sy, input bit rw);
    sel = s; rand_wait = rw; run_id++; sx_g = sx; sy_g = sy;
    for (int i = 0; i < 64; i++) smem[i] = bd[i];
    ref_model(sx, sy, MASKS[s], STEPS[s], MAXB[s]);
    r0 = n_rd; w0 = n_wr; b0 = bad_acc;
    wr(4'd1, 32'h1000);
    wr(4'd2, 32'h2000);
    wr(4'd3, 32'(sx));
    wr(4'd4, 32'(sy));
    wr(4'd0, 32'd0);
  endtask

  task automatic finish_run(input string tag);
    logic [31:0] v;
    int cyc, bad, sq, e;
    cyc = 0; v = '0;
    while (v != 32'd2 && cyc < 40000) begin cpu_read(4'd0, v); cyc++; end
    check({tag, " status_done"}, v, 32'd2);
    cpu_read(4'd0, v);
    check({tag, " status_clear"}, v, 32'd0);
    cpu_read(4'd5, v);
    last_count = int'(v);
    check({tag, " count"}, v, 32'(exp_t.size()));
    check({tag, " reads"}, 32'(n_rd - r0), 32'(exp_reads));
    check({tag, " writes"}, 32'(n_wr - w0), 32'(64 * exp_t.size()));
    check({tag, " bus_errors"}, 32'(bad_acc - b0), 32'd0);
    bad = 0;
    sq = 8 * sy_g + sx_g;
    for (int n = 0; n < exp_t.size(); n++) begin
      for (int i = 0; i < 64; i++) begin
        e = (i == exp_t[n]) ? bd[sq] : (i == sq) ? 0 : bd[i];
        if (dtag[64 * n + i] != run_id || dmem[64 * n + i] != 32'(e)) bad++;
      end
    end
    check({tag, " boards"}, 32'(bad), 32'd0);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) bd[i] = 0;
  endtask

  logic [31:0] v;
  logic [31:0] snap [DW];
  int          stall, cyc, diff;

  initial begin
    // ---- reset state
    repeat (3) @(posedge clk);
    check("rst master_read", 32'(cur_read), 32'd0);
    check("rst master_write", 32'(cur_write), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cpu_read(4'd0, v); check("rst status", v, 32'd0);
    cpu_read(4'd5, v); check("rst count", v, 32'd0);
    cpu_read(4'd6, v); check("queen dir_mask", v, 32'h0000_00FF);
    cpu_read(4'd7, v); check("unused reg", v, 32'd0);
    sel = 1;
    cpu_read(4'd6, v); check("rook dir_mask", v, 32'h0000_0055);

    // ---- rook in the corner of an empty board
    clear_board(); bd[0] = 4;
    start_run(1, 0, 0, 1'b0);
    finish_run("rook_corner");
    check("rook_corner n", 32'(last_count), 32'd14);
    check("rook_corner b0 tgt", dmem[8], 32'd4);
    check("rook_corner b0 src", dmem[0], 32'd0);

    // ---- queen with a friendly blocker and an enemy piece
    clear_board(); bd[27] = 5; bd[43] = 1; bd[45] = -2;
    start_run(0, 3, 3, 1'b0);
    finish_run("queen_block");
    check("queen b0 tgt N", dmem[35], 32'd5);
    check("queen b0 src", dmem[27], 32'd0);
    check("queen b0 blocker", dmem[43], 32'd1);
    check("queen b1 tgt NE", dmem[64 + 36], 32'd5);
    check("queen b2 capture", dmem[128 + 45], 32'd5);
    for (int i = 0; i < DW; i++) snap[i] = dmem[i];

    // ---- same position under random stalls and read latency
    start_run(0, 3, 3, 1'b1);
    finish_run("queen_stall");
    diff = 0;
    for (int i = 0; i < 64 * exp_t.size(); i++) if (dmem[i] != snap[i]) diff++;
    check("queen_stall identical", 32'(diff), 32'd0);

    // ---- king in the corner, then king in the centre with a 4-deep list
    clear_board(); bd[63] = -6;
    start_run(2, 7, 7, 1'b0);
    finish_run("king_corner");
    check("king_corner n", 32'(last_count), 32'd3);
    clear_board(); bd[27] = 6;
    start_run(2, 3, 3, 1'b1);
    finish_run("king_full");
    check("king_full n", 32'(last_count), 32'd4);

    // ---- empty source square
    clear_board(); bd[20] = 3;
    start_run(0, 2, 2, 1'b0);
    finish_run("empty_src");

    // ---- CPU write while busy is stalled until completion
    clear_board(); bd[36] = -5;
    start_run(0, 4, 4, 1'b1);
    cpu_write(4'd3, 32'd7, stall);
    check("busy write stalled", 32'(stall > 50), 32'd1);
    finish_run("busy_write");

    // ---- randomized boards
    for (int r = 0; r < 6; r++) begin
      int s, x, y;
      s = int'($urandom_range(0, 2));
      x = int'($urandom_range(0, 7));
      y = int'($urandom_range(0, 7));
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 99) < 40) begin
          bd[i] = int'($urandom_range(1, 6));
          if ($urandom_range(0, 1) == 1) bd[i] = -bd[i];
        end else begin
          bd[i] = 0;
        end
      end
      bd[8 * y + x] = ($urandom_range(0, 1) == 1) ? 3 : -3;
      start_run(s, x, y, 1'(r));
      finish_run("random");
    end

    // ---- asynchronous reset in the middle of the copy phase
    clear_board(); bd[27] = 2;
    start_run(0, 3, 3, 1'b0);
    cyc = 0;
    while ((n_wr - w0) < 5 && cyc < 20000) begin @(negedge clk); cyc++; end
    while (!(cur_read || cur_write) && cyc < 20000) begin @(negedge clk); cyc++; end
    check("midcopy reached", 32'(cur_read || cur_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async master_read", 32'(cur_read), 32'd0);
    check("async master_write", 32'(cur_write), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cpu_read(4'd0, v); check("post_rst status", v, 32'd0);
    cpu_read(4'd5, v); check("post_rst count", v, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
